// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller request port among NUM_PORTS masters.
// An in-order tag FIFO steers each completion back to the master that issued the request.
module sdram_port_arbiter #(
    parameter int NUM_PORTS       = 4,
    parameter int ID_W            = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_PORTS*4-1:0]    req_wr_i,
    input  logic [NUM_PORTS-1:0]      req_rd_i,
    input  logic [NUM_PORTS*32-1:0]   req_addr_i,
    input  logic [NUM_PORTS*32-1:0]   req_write_data_i,
    output logic [NUM_PORTS-1:0]      req_accept_o,
    output logic [NUM_PORTS-1:0]      req_ack_o,
    output logic [NUM_PORTS-1:0]      req_error_o,
    output logic [31:0]               req_read_data_o,
    output logic [3:0]                mem_wr_o,
    output logic                      mem_rd_o,
    output logic [31:0]               mem_addr_o,
    output logic [31:0]               mem_write_data_o,
    input  logic                      mem_accept_i,
    input  logic                      mem_ack_i,
    input  logic                      mem_error_i,
    input  logic [31:0]               mem_read_data_i,
    output logic                      protocol_err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   prio_q, prio_d;
    logic [CNT_W-1:0]  count_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [ID_W-1:0]   tag_mem [MAX_OUTSTANDING];

    logic [NUM_PORTS-1:0] port_req;
    logic                 found;
    logic [ID_W-1:0]      pick;
    logic                 grant_req;
    logic                 sel_rd;
    logic [3:0]           sel_wr;
    logic                 drive;
    logic                 push;
    logic                 pop;
    logic [ID_W-1:0]      head_tag;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_req[p] = req_rd_i[p] | (|req_wr_i[p*4 +: 4]);
        end
    end

    // Outer loop walks distance from prio_q, so the first hit is the nearest requester.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (!found && port_req[p] &&
                    prio_q == ID_W'((p - i + NUM_PORTS) % NUM_PORTS)) begin
                    found = 1'b1;
                    pick  = ID_W'(p);
                end
            end
        end
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path leaves a latch.
        state_d          = state_q;
        grant_d          = grant_q;
        prio_d           = prio_q;
        grant_req        = 1'b0;
        sel_rd           = 1'b0;
        sel_wr           = '0;
        drive            = 1'b0;
        push             = 1'b0;
        mem_rd_o         = 1'b0;
        mem_wr_o         = '0;
        mem_addr_o       = '0;
        mem_write_data_o = '0;

        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant_q == ID_W'(p)) begin
                grant_req        = port_req[p];
                sel_rd           = req_rd_i[p];
                sel_wr           = req_wr_i[p*4 +: 4];
                mem_addr_o       = req_addr_i[p*32 +: 32];
                mem_write_data_o = req_write_data_i[p*32 +: 32];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Stall uses registered count_q only: no mem_ack_i -> mem_rd_o/mem_wr_o path.
                drive = grant_req && (count_q < CNT_W'(MAX_OUTSTANDING));
                if (drive) begin
                    mem_rd_o = sel_rd;
                    mem_wr_o = sel_wr;
                    push     = mem_accept_i;
                end
                if (push) begin
                    state_d = ST_IDLE;
                    prio_d  = (grant_q == ID_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
                end else if (!grant_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst_i) begin
            mem_rd_o = 1'b0;
            mem_wr_o = '0;
            push     = 1'b0;
        end
    end

    assign pop             = mem_ack_i && (count_q != '0) && !rst_i;
    assign head_tag        = tag_mem[rd_ptr_q];
    assign req_read_data_o = mem_read_data_i;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            req_accept_o[p] = push && (grant_q == ID_W'(p));
            req_ack_o[p]    = pop && (head_tag == ID_W'(p));
            req_error_o[p]  = pop && (head_tag == ID_W'(p)) && mem_error_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            prio_q         <= '0;
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            protocol_err_o <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
            if (mem_ack_i && count_q == '0) protocol_err_o <= 1'b1;
        end
    end

    // NOTE: tag storage is not reset; entries are only read after a push has written them.
    always_ff @(posedge clk_i) begin
        if (push) tag_mem[wr_ptr_q] <= grant_q;
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter (4 ports, 2 outstanding).
// Inputs change 1 time unit after each rising edge; outputs are checked mid-cycle.
module tb_sdram_port_arbiter;

    localparam int NP = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NP*4-1:0]   req_wr_i;
    logic [NP-1:0]     req_rd_i;
    logic [NP*32-1:0]  req_addr_i;
    logic [NP*32-1:0]  req_write_data_i;
    logic [NP-1:0]     req_accept_o;
    logic [NP-1:0]     req_ack_o;
    logic [NP-1:0]     req_error_o;
    logic [31:0]       req_read_data_o;
    logic [3:0]        mem_wr_o;
    logic              mem_rd_o;
    logic [31:0]       mem_addr_o;
    logic [31:0]       mem_write_data_o;
    logic              mem_accept_i;
    logic              mem_ack_i;
    logic              mem_error_i;
    logic [31:0]       mem_read_data_i;
    logic              protocol_err_o;

    int vectors = 0;
    int miscompares = 0;

    sdram_port_arbiter #(.NUM_PORTS(NP), .ID_W(2), .MAX_OUTSTANDING(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_wr_i(req_wr_i), .req_rd_i(req_rd_i), .req_addr_i(req_addr_i),
        .req_write_data_i(req_write_data_i), .req_accept_o(req_accept_o),
        .req_ack_o(req_ack_o), .req_error_o(req_error_o), .req_read_data_o(req_read_data_o),
        .mem_wr_o(mem_wr_o), .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o),
        .mem_write_data_o(mem_write_data_o), .mem_accept_i(mem_accept_i),
        .mem_ack_i(mem_ack_i), .mem_error_i(mem_error_i), .mem_read_data_i(mem_read_data_i),
        .protocol_err_o(protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_port(input int p, input logic rd, input logic [3:0] wr,
                            input logic [31:0] addr, input logic [31:0] data);
        req_rd_i[p]                 = rd;
        req_wr_i[p*4 +: 4]          = wr;
        req_addr_i[p*32 +: 32]      = addr;
        req_write_data_i[p*32 +: 32] = data;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req_wr_i = '0; req_rd_i = '0; req_addr_i = '0; req_write_data_i = '0;
        mem_accept_i = 1'b0; mem_ack_i = 1'b0; mem_error_i = 1'b0; mem_read_data_i = '0;
        tick();
        tick();
        vectors++;
        if ({req_accept_o, req_ack_o, req_error_o, mem_rd_o, mem_wr_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_strobes: got %h, expected 0",
                     {req_accept_o, req_ack_o, req_error_o, mem_rd_o, mem_wr_o});
        end
        vectors++;
        if (protocol_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_protocol_err: got %b, expected 0", protocol_err_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_single_read();
        set_port(2, 1'b1, 4'h0, 32'h0000_1000, 32'h0);
        mem_accept_i = 1'b1;
        #1;
        vectors++;
        if (req_accept_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL read_no_early_accept: got %b, expected 0000", req_accept_o);
        end
        tick();
        vectors++;
        if (mem_rd_o !== 1'b1 || mem_addr_o !== 32'h0000_1000) begin
            miscompares++;
            $display("FAIL read_issue: got rd=%b addr=%h, expected rd=1 addr=00001000", mem_rd_o, mem_addr_o);
        end
        vectors++;
        if (req_accept_o !== 4'b0100) begin
            miscompares++;
            $display("FAIL read_accept: got %b, expected 0100", req_accept_o);
        end
        tick();
        set_port(2, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        vectors++;
        if (mem_rd_o !== 1'b0) begin
            miscompares++;
            $display("FAIL read_idle_bubble: got rd=%b, expected 0", mem_rd_o);
        end
        mem_ack_i = 1'b1;
        mem_read_data_i = 32'hDEAD_BEEF;
        #1;
        vectors++;
        if (req_ack_o !== 4'b0100 || req_read_data_o !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL read_ack: got ack=%b data=%h, expected ack=0100 data=deadbeef",
                     req_ack_o, req_read_data_o);
        end
        tick();
        mem_ack_i = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        apply_reset();
        req_rd_i = 4'hF;
        mem_accept_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp = 4'b0001 << (k % 4);
            tick();
            mem_ack_i = 1'b0;
            #1;
            vectors++;
            if (req_accept_o !== exp) begin
                miscompares++;
                $display("FAIL rr_accept[%0d]: got %b, expected %b", k, req_accept_o, exp);
            end
            tick();
            mem_ack_i = 1'b1;
            #1;
            vectors++;
            if (req_ack_o !== exp || req_accept_o !== 4'b0000) begin
                miscompares++;
                $display("FAIL rr_ack_bubble[%0d]: got ack=%b accept=%b, expected ack=%b accept=0000",
                         k, req_ack_o, req_accept_o, exp);
            end
        end
        tick();
        mem_ack_i = 1'b0;
        mem_accept_i = 1'b0;
        req_rd_i = '0;
        tick();
        vectors++;
        if (protocol_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_protocol_err: got %b, expected 0", protocol_err_o);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        set_port(0, 1'b1, 4'h0, 32'h0000_0100, 32'h0);
        set_port(1, 1'b1, 4'h0, 32'h0000_0200, 32'h0);
        set_port(2, 1'b1, 4'h0, 32'h0000_0300, 32'h0);
        mem_accept_i = 1'b1;
        tick();
        vectors++;
        if (req_accept_o !== 4'b0001) begin
            miscompares++;
            $display("FAIL stall_first: got %b, expected 0001", req_accept_o);
        end
        tick();
        set_port(0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        vectors++;
        if (req_accept_o !== 4'b0010) begin
            miscompares++;
            $display("FAIL stall_second: got %b, expected 0010", req_accept_o);
        end
        tick();
        set_port(1, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        for (int c = 0; c < 2; c++) begin
            vectors++;
            if (mem_rd_o !== 1'b0 || req_accept_o !== 4'b0000) begin
                miscompares++;
                $display("FAIL stall_held[%0d]: got rd=%b accept=%b, expected rd=0 accept=0000",
                         c, mem_rd_o, req_accept_o);
            end
            if (c == 0) tick();
        end
        mem_ack_i = 1'b1;
        #1;
        vectors++;
        if (req_ack_o !== 4'b0001 || mem_rd_o !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_ack_same_cycle: got ack=%b rd=%b, expected ack=0001 rd=0", req_ack_o, mem_rd_o);
        end
        tick();
        mem_ack_i = 1'b0;
        #1;
        vectors++;
        if (mem_rd_o !== 1'b1 || req_accept_o !== 4'b0100 || mem_addr_o !== 32'h0000_0300) begin
            miscompares++;
            $display("FAIL stall_release: got rd=%b accept=%b addr=%h, expected rd=1 accept=0100 addr=00000300",
                     mem_rd_o, req_accept_o, mem_addr_o);
        end
        tick();
        set_port(2, 1'b0, 4'h0, 32'h0, 32'h0);
        mem_ack_i = 1'b1;
        #1;
        vectors++;
        if (req_ack_o !== 4'b0010) begin
            miscompares++;
            $display("FAIL stall_drain1: got %b, expected 0010", req_ack_o);
        end
        tick();
        vectors++;
        if (req_ack_o !== 4'b0100) begin
            miscompares++;
            $display("FAIL stall_drain2: got %b, expected 0100", req_ack_o);
        end
        tick();
        mem_ack_i = 1'b0;
    endtask

    task automatic test_writes_error();
        set_port(1, 1'b0, 4'hF, 32'h0000_2000, 32'h1111_1111);
        mem_accept_i = 1'b1;
        tick();
        vectors++;
        if (mem_wr_o !== 4'hF || mem_write_data_o !== 32'h1111_1111 || req_accept_o !== 4'b0010) begin
            miscompares++;
            $display("FAIL wr_port1: got wr=%h data=%h accept=%b, expected wr=f data=11111111 accept=0010",
                     mem_wr_o, mem_write_data_o, req_accept_o);
        end
        tick();
        set_port(1, 1'b0, 4'h0, 32'h0, 32'h0);
        set_port(3, 1'b0, 4'h3, 32'h0000_3000, 32'h3333_3333);
        tick();
        vectors++;
        if (mem_wr_o !== 4'h3 || mem_addr_o !== 32'h0000_3000 || req_accept_o !== 4'b1000) begin
            miscompares++;
            $display("FAIL wr_port3: got wr=%h addr=%h accept=%b, expected wr=3 addr=00003000 accept=1000",
                     mem_wr_o, mem_addr_o, req_accept_o);
        end
        tick();
        set_port(3, 1'b0, 4'h0, 32'h0, 32'h0);
        mem_ack_i = 1'b1;
        mem_error_i = 1'b0;
        #1;
        vectors++;
        if (req_ack_o !== 4'b0010 || req_error_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL wr_ack1: got ack=%b err=%b, expected ack=0010 err=0000", req_ack_o, req_error_o);
        end
        tick();
        mem_error_i = 1'b1;
        #1;
        vectors++;
        if (req_ack_o !== 4'b1000 || req_error_o !== 4'b1000) begin
            miscompares++;
            $display("FAIL wr_ack2: got ack=%b err=%b, expected ack=1000 err=1000", req_ack_o, req_error_o);
        end
        tick();
        mem_ack_i = 1'b0;
        mem_error_i = 1'b0;
    endtask

    task automatic test_protocol_err();
        mem_ack_i = 1'b1;
        #1;
        vectors++;
        if (req_ack_o !== 4'b0000 || protocol_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL perr_no_ack: got ack=%b perr=%b, expected ack=0000 perr=0", req_ack_o, protocol_err_o);
        end
        tick();
        mem_ack_i = 1'b0;
        tick();
        tick();
        vectors++;
        if (protocol_err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL perr_sticky: got %b, expected 1", protocol_err_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        vectors++;
        if (protocol_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL perr_cleared: got %b, expected 0", protocol_err_o);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mem_accept_i = 1'b1;
        set_port(1, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
        tick();
        tick();
        set_port(1, 1'b0, 4'h0, 32'h0, 32'h0);
        set_port(2, 1'b1, 4'h0, 32'h0000_0020, 32'h0);
        tick();
        tick();
        set_port(2, 1'b0, 4'h0, 32'h0, 32'h0);
        set_port(0, 1'b1, 4'h0, 32'h0000_0030, 32'h0);
        tick();
        vectors++;
        if (mem_rd_o !== 1'b0 || mem_addr_o !== 32'h0000_0030) begin
            miscompares++;
            $display("FAIL mid_p0_stalled: got rd=%b addr=%h, expected rd=0 addr=00000030", mem_rd_o, mem_addr_o);
        end
        rst_i = 1'b1;
        mem_ack_i = 1'b1;
        #1;
        vectors++;
        if ({req_accept_o, req_ack_o, req_error_o, mem_rd_o, mem_wr_o} !== '0) begin
            miscompares++;
            $display("FAIL mid_rst_strobes: got %h, expected 0",
                     {req_accept_o, req_ack_o, req_error_o, mem_rd_o, mem_wr_o});
        end
        tick();
        mem_ack_i = 1'b0;
        rst_i = 1'b0;
        set_port(0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_port(3, 1'b1, 4'h0, 32'h0000_0040, 32'h0);
        #1;
        vectors++;
        if (mem_rd_o !== 1'b0 || req_accept_o !== 4'b0000 || protocol_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_after_rst: got rd=%b accept=%b perr=%b, expected 0 0000 0",
                     mem_rd_o, req_accept_o, protocol_err_o);
        end
        tick();
        vectors++;
        if (mem_rd_o !== 1'b1 || req_accept_o !== 4'b1000) begin
            miscompares++;
            $display("FAIL mid_new_grant: got rd=%b accept=%b, expected rd=1 accept=1000", mem_rd_o, req_accept_o);
        end
        tick();
        set_port(3, 1'b0, 4'h0, 32'h0, 32'h0);
        mem_ack_i = 1'b1;
        #1;
        vectors++;
        if (req_ack_o !== 4'b1000) begin
            miscompares++;
            $display("FAIL mid_only_new_tag: got %b, expected 1000", req_ack_o);
        end
        tick();
        vectors++;
        if (req_ack_o !== 4'b0000) begin
            miscompares++;
            $display("FAIL mid_old_tags_gone: got %b, expected 0000", req_ack_o);
        end
        tick();
        mem_ack_i = 1'b0;
        #1;
        vectors++;
        if (protocol_err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_empty_ack_perr: got %b, expected 1", protocol_err_o);
        end
        mem_accept_i = 1'b0;
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_stall();
        test_writes_error();
        test_protocol_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
